apuf_eval_ctrl: RTL and testbench

//  Sequencer for one XOR_8_APUF instance. Accepts a 32-bit challenge over a Start/Done handshake.

---
 rtl/apuf_eval_ctrl_if.sv | 24 ++
 rtl/apuf_eval_ctrl.sv | 141 ++++++++++++++
 tb/tb_apuf_eval_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apuf_eval_ctrl_if.sv
// Host/array-facing signal bundle of the APUF evaluation sequencer.
// master = host command logic plus array model, slave = the sequencer itself.
interface apuf_eval_ctrl_if;
    logic        Start;
    logic [31:0] Challenge_in;
    logic        Busy;
    logic        Done;
    logic [7:0]  Response;
    logic [7:0]  Stable;
    logic [31:0] APUF_Challenge;
    logic        APUF_Pulse;
    logic        APUF_Reset;
    logic [7:0]  APUF_Result;

    modport master (
        output Start, Challenge_in, APUF_Result,
        input  Busy, Done, Response, Stable, APUF_Challenge, APUF_Pulse, APUF_Reset
    );

    modport slave (
        input  Start, Challenge_in, APUF_Result,
        output Busy, Done, Response, Stable, APUF_Challenge, APUF_Pulse, APUF_Reset
    );
endinterface

// File: rtl/apuf_eval_ctrl.sv
// Sequencer for one XOR_8_APUF array: repeats reset/setup/fire/settle/sample
// NUM_EVALS times per challenge, then majority-votes each result bit.
module apuf_eval_ctrl #(
    parameter int unsigned NUM_EVALS     = 5,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned PULSE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    apuf_eval_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W  = $clog2(NUM_EVALS + 1);
    localparam int unsigned MAX_RS = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
    localparam int unsigned MAX_PS = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_PH = (MAX_RS > MAX_PS) ? MAX_RS : MAX_PS;
    localparam int unsigned PH_W   = $clog2(MAX_PH + 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, SETUP, FIRE, SETTLE, SAMPLE, DONE
    } state_t;

    state_t                  state;
    logic [PH_W-1:0]         phaseCnt;
    logic [CNT_W-1:0]        evalCnt;
    logic [7:0][CNT_W-1:0]   onesCnt;
    logic [7:0]              resultMeta;
    logic [7:0]              resultSync;

    logic [7:0][CNT_W-1:0]   onesNext;
    logic [7:0]              respNext;
    logic [7:0]              stabNext;
    logic                    phaseEnd;
    logic                    lastEval;

    // Vote on the counts including the sample being taken this cycle, so
    // Response/Stable can be loaded on the same edge that enters DONE.
    always_comb begin
        onesNext = onesCnt;
        respNext = '0;
        stabNext = '0;
        for (int i = 0; i < 8; i++) begin
            onesNext[i] = onesCnt[i] + CNT_W'(resultSync[i]);
            respNext[i] = {onesNext[i], 1'b0} > (CNT_W + 1)'(NUM_EVALS);
            stabNext[i] = (onesNext[i] == '0) || (onesNext[i] == CNT_W'(NUM_EVALS));
        end
    end

    assign phaseEnd = (phaseCnt == '0);
    assign lastEval = (evalCnt == CNT_W'(NUM_EVALS - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state              <= IDLE;
            phaseCnt           <= '0;
            evalCnt            <= '0;
            onesCnt            <= '0;
            resultMeta         <= '0;
            resultSync         <= '0;
            bus.Busy           <= 1'b0;
            bus.Done           <= 1'b0;
            bus.Response       <= '0;
            bus.Stable         <= '0;
            bus.APUF_Challenge <= '0;
            bus.APUF_Pulse     <= 1'b0;
            bus.APUF_Reset     <= 1'b1;
        end else begin
            resultMeta <= bus.APUF_Result;
            resultSync <= resultMeta;

            // Each phase counter is loaded with length-1 on entry and counts down.
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state              <= CLEAR;
                        bus.Busy           <= 1'b1;
                        bus.APUF_Challenge <= bus.Challenge_in;
                        evalCnt            <= '0;
                        onesCnt            <= '0;
                        phaseCnt           <= PH_W'(RST_CYCLES - 1);
                    end
                end
                CLEAR: begin
                    if (phaseEnd) begin
                        state          <= SETUP;
                        bus.APUF_Reset <= 1'b0;
                        phaseCnt       <= PH_W'(SETUP_CYCLES - 1);
                    end else begin
                        phaseCnt <= phaseCnt - PH_W'(1);
                    end
                end
                SETUP: begin
                    if (phaseEnd) begin
                        state          <= FIRE;
                        bus.APUF_Pulse <= 1'b1;
                        phaseCnt       <= PH_W'(PULSE_CYCLES - 1);
                    end else begin
                        phaseCnt <= phaseCnt - PH_W'(1);
                    end
                end
                FIRE: begin
                    if (phaseEnd) begin
                        state          <= SETTLE;
                        bus.APUF_Pulse <= 1'b0;
                        phaseCnt       <= PH_W'(SETTLE_CYCLES - 1);
                    end else begin
                        phaseCnt <= phaseCnt - PH_W'(1);
                    end
                end
                SETTLE: begin
                    if (phaseEnd) begin
                        state <= SAMPLE;
                    end else begin
                        phaseCnt <= phaseCnt - PH_W'(1);
                    end
                end
                SAMPLE: begin
                    onesCnt        <= onesNext;
                    evalCnt        <= evalCnt + CNT_W'(1);
                    bus.APUF_Reset <= 1'b1;
                    if (lastEval) begin
                        state        <= DONE;
                        bus.Done     <= 1'b1;
                        bus.Response <= respNext;
                        bus.Stable   <= stabNext;
                    end else begin
                        state    <= CLEAR;
                        phaseCnt <= PH_W'(RST_CYCLES - 1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.Done <= 1'b0;
                    bus.Busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Bench for apuf_eval_ctrl: two instances (5 and 4 evaluations) checked every
// cycle against a cycle-offset reference model plus scripted corner cases.
module tb_apuf_eval_ctrl;
    localparam int unsigned RSTC    = 4;
    localparam int unsigned SETUPC  = 2;
    localparam int unsigned PULSEC  = 4;
    localparam int unsigned SETTLEC = 8;
    localparam int unsigned EV      = RSTC + SETUPC + PULSEC + SETTLEC + 1;
    localparam int unsigned NA      = 5;
    localparam int unsigned NB      = 4;

    logic clk;
    logic rstN;

    apuf_eval_ctrl_if ifA();
    apuf_eval_ctrl_if ifB();

    apuf_eval_ctrl #(.NUM_EVALS(NA)) dutA (.Clk(clk), .Reset_n(rstN), .bus(ifA.slave));
    apuf_eval_ctrl #(.NUM_EVALS(NB)) dutB (.Clk(clk), .Reset_n(rstN), .bus(ifB.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance: mT = cycles since accept (0 = idle).
    int unsigned mT [2];
    logic [7:0]  mSeq [2][8];
    logic [7:0]  mResp [2];
    logic [7:0]  mStab [2];
    logic [31:0] mChal [2];
    int unsigned doneCnt [2];

    typedef struct {
        int unsigned dut;
        logic [31:0] chal;
        logic [7:0]  seq [5];
        logic [7:0]  resp;
        logic [7:0]  stab;
        int unsigned doneAt;
    } vec_t;
    vec_t tbl [4];

    function automatic int unsigned nOf(int unsigned d);
        return (d == 0) ? NA : NB;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Majority and unanimity over the scripted samples, counted bit by bit.
    function automatic void refVote(int unsigned d);
        int unsigned n;
        int unsigned ones;
        n = nOf(d);
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int unsigned k = 0; k < n; k++) ones += int'(mSeq[d][k][b]);
            mResp[d][b] = (2 * ones > n);
            mStab[d][b] = (ones == 0) || (ones == n);
        end
    endfunction

    // Per-cycle comparison against the expected waveform, then model step and array drive.
    always @(negedge clk) begin
        logic [3:0]  obsCtl [2];
        logic [7:0]  obsResp [2];
        logic [7:0]  obsStab [2];
        logic [31:0] obsChal [2];
        logic        obsStart [2];
        logic [31:0] obsChalIn [2];
        logic [7:0]  drv [2];
        logic [3:0]  expCtl;
        int unsigned n;
        int unsigned last;
        int unsigned p;
        int unsigned k;

        obsCtl[0]  = {ifA.Busy, ifA.Done, ifA.APUF_Reset, ifA.APUF_Pulse};
        obsCtl[1]  = {ifB.Busy, ifB.Done, ifB.APUF_Reset, ifB.APUF_Pulse};
        obsResp[0] = ifA.Response;        obsResp[1] = ifB.Response;
        obsStab[0] = ifA.Stable;          obsStab[1] = ifB.Stable;
        obsChal[0] = ifA.APUF_Challenge;  obsChal[1] = ifB.APUF_Challenge;
        obsStart[0] = ifA.Start;          obsStart[1] = ifB.Start;
        obsChalIn[0] = ifA.Challenge_in;  obsChalIn[1] = ifB.Challenge_in;

        for (int unsigned d = 0; d < 2; d++) begin
            n    = nOf(d);
            last = 1 + n * EV;
            if (!rstN) begin
                mT[d] = 0; mResp[d] = '0; mStab[d] = '0; mChal[d] = '0;
            end
            p = (mT[d] >= 1) ? (mT[d] - 1) % EV : 0;
            expCtl[3] = (mT[d] != 0);
            expCtl[2] = (mT[d] == last);
            expCtl[1] = (mT[d] == 0) || (mT[d] == last) || (p < RSTC);
            expCtl[0] = (mT[d] != 0) && (mT[d] != last) &&
                        (p >= RSTC + SETUPC) && (p < RSTC + SETUPC + PULSEC);
            check($sformatf("ctl_bdrp%0d", d), 64'(obsCtl[d]), 64'(expCtl));
            check($sformatf("resp%0d", d), 64'(obsResp[d]), 64'(mResp[d]));
            check($sformatf("stab%0d", d), 64'(obsStab[d]), 64'(mStab[d]));
            check($sformatf("chal%0d", d), 64'(obsChal[d]), 64'(mChal[d]));
            if (obsCtl[d][2] === 1'b1) doneCnt[d]++;

            if (rstN) begin
                if (mT[d] == 0) begin
                    if (obsStart[d] === 1'b1) begin
                        mT[d]   = 1;
                        mChal[d] = obsChalIn[d];
                    end
                end else if (mT[d] == last) begin
                    mT[d] = 0;
                end else begin
                    mT[d]++;
                    if (mT[d] == last) refVote(d);
                end
            end

            // Array model: garbage until the pulse has fallen, then this evaluation's value.
            if (mT[d] >= 1 && mT[d] < last) begin
                k = (mT[d] - 1) / EV;
                p = (mT[d] - 1) % EV;
                drv[d] = (p >= RSTC + SETUPC + PULSEC) ? mSeq[d][k] : ~mSeq[d][k];
            end else begin
                drv[d] = 8'($urandom);
            end
        end
        ifA.APUF_Result = drv[0];
        ifB.APUF_Result = drv[1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(int unsigned d, logic s, logic [31:0] c);
        if (d == 0) begin ifA.Start = s; ifA.Challenge_in = c; end
        else        begin ifB.Start = s; ifB.Challenge_in = c; end
    endtask

    function automatic logic getDone(int unsigned d);
        return (d == 0) ? ifA.Done : ifB.Done;
    endfunction

    function automatic logic getBusy(int unsigned d);
        return (d == 0) ? ifA.Busy : ifB.Busy;
    endfunction

    function automatic logic [7:0] getResp(int unsigned d);
        return (d == 0) ? ifA.Response : ifB.Response;
    endfunction

    function automatic logic [7:0] getStab(int unsigned d);
        return (d == 0) ? ifA.Stable : ifB.Stable;
    endfunction

    function automatic logic [31:0] getChal(int unsigned d);
        return (d == 0) ? ifA.APUF_Challenge : ifB.APUF_Challenge;
    endfunction

    // Start held for cycle 0 only; returns in cycle 1.
    task automatic startRun(int unsigned d, logic [31:0] c);
        setIn(d, 1'b1, c);
        tick();
        setIn(d, 1'b0, $urandom);
    endtask

    task automatic waitDone(int unsigned d, int unsigned maxCyc, output int unsigned cyc);
        cyc = 1;
        while (getDone(d) !== 1'b1 && cyc < maxCyc) begin
            tick();
            cyc++;
        end
        if (getDone(d) !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout%0d: no Done within %0d cycles", d, maxCyc);
        end
    endtask

    task automatic fillRandom(int unsigned d);
        for (int k = 0; k < 8; k++) mSeq[d][k] = 8'($urandom);
    endtask

    task automatic setRow(int i, int unsigned d, logic [31:0] c,
                          logic [7:0] s0, logic [7:0] s1, logic [7:0] s2,
                          logic [7:0] s3, logic [7:0] s4,
                          logic [7:0] r, logic [7:0] s, int unsigned at);
        tbl[i].dut = d;  tbl[i].chal = c;
        tbl[i].seq[0] = s0; tbl[i].seq[1] = s1; tbl[i].seq[2] = s2;
        tbl[i].seq[3] = s3; tbl[i].seq[4] = s4;
        tbl[i].resp = r; tbl[i].stab = s; tbl[i].doneAt = at;
    endtask

    initial begin
        int unsigned cyc;
        int unsigned d;
        int unsigned base;

        for (int i = 0; i < 2; i++) begin
            mT[i] = 0; mResp[i] = '0; mStab[i] = '0; mChal[i] = '0; doneCnt[i] = 0;
            for (int k = 0; k < 8; k++) mSeq[i][k] = '0;
        end
        rstN = 1'b0;
        setIn(0, 1'b0, '0);
        setIn(1, 1'b0, '0);

        setRow(0, 0, 32'hDEADBEEF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 96);
        setRow(1, 0, 32'h00000001, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 8'hFE, 96);
        setRow(2, 1, 32'hF00DFACE, 8'h89, 8'h89, 8'h81, 8'h80, 8'h00, 8'h81, 8'hF6, 77);
        setRow(3, 0, 32'h13579BDF, 8'h0F, 8'hF0, 8'hFF, 8'h00, 8'h3C, 8'h3C, 8'h00, 96);

        repeat (3) tick();
        check("rst_vals", {ifA.Busy, ifA.Done, ifA.Response, ifA.Stable,
                           ifA.APUF_Challenge, ifA.APUF_Pulse, ifA.APUF_Reset}, 64'h1);
        rstN = 1'b1;
        repeat (2) tick();

        // Scripted vectors: fixed value, alternating bit, even-count tie, mixed.
        for (int i = 0; i < 4; i++) begin
            d = tbl[i].dut;
            for (int k = 0; k < 8; k++) mSeq[d][k] = (k < 5) ? tbl[i].seq[k] : 8'h00;
            startRun(d, tbl[i].chal);
            waitDone(d, 300, cyc);
            check($sformatf("vec%0d_done_cyc", i), 64'(cyc), 64'(tbl[i].doneAt));
            check($sformatf("vec%0d_resp", i), 64'(getResp(d)), 64'(tbl[i].resp));
            check($sformatf("vec%0d_stab", i), 64'(getStab(d)), 64'(tbl[i].stab));
            check($sformatf("vec%0d_chal", i), 64'(getChal(d)), 64'(tbl[i].chal));
            tick();
            check($sformatf("vec%0d_busy_after", i), 64'(getBusy(d)), 64'h0);
        end

        // Randomised results on both instances, back to back.
        for (int r = 0; r < 8; r++) begin
            d = r % 2;
            fillRandom(d);
            startRun(d, $urandom);
            waitDone(d, 300, cyc);
            check($sformatf("rnd%0d_done_cyc", r), 64'(cyc), 64'(1 + nOf(d) * EV));
            check($sformatf("rnd%0d_resp", r), 64'(getResp(d)), 64'(mResp[d]));
            check($sformatf("rnd%0d_stab", r), 64'(getStab(d)), 64'(mStab[d]));
            tick();
        end

        // Starts while busy are dropped; a Start right after Done is taken.
        fillRandom(0);
        base = doneCnt[0];
        startRun(0, 32'h12345678);
        cyc = 1;
        while (cyc < 10) begin tick(); cyc++; end
        setIn(0, 1'b1, 32'hCAFE0001); tick(); cyc++; setIn(0, 1'b0, $urandom);
        while (cyc < 50) begin tick(); cyc++; end
        setIn(0, 1'b1, 32'hCAFE0002); tick(); cyc++; setIn(0, 1'b0, $urandom);
        while (getDone(0) !== 1'b1 && cyc < 300) begin tick(); cyc++; end
        check("ign_done_cyc", 64'(cyc), 64'd96);
        check("ign_chal", 64'(getChal(0)), 64'h12345678);
        tick();
        check("ign_one_done", 64'(doneCnt[0] - base), 64'd1);
        fillRandom(0);
        startRun(0, 32'h0BADF00D);
        check("b2b_busy", 64'(getBusy(0)), 64'h1);
        check("b2b_chal", 64'(getChal(0)), 64'h0BADF00D);
        waitDone(0, 300, cyc);
        check("b2b_done_cyc", 64'(cyc), 64'd96);
        tick();

        // Reset during the third evaluation's FIRE aborts the run silently.
        fillRandom(0);
        startRun(0, 32'h5555AAAA);
        cyc = 1;
        while (cyc < 47) begin tick(); cyc++; end
        check("abort_in_fire", 64'(ifA.APUF_Pulse), 64'h1);
        base = doneCnt[0];
        rstN = 1'b0;
        #1;
        check("abort_async", {ifA.Busy, ifA.Done, ifA.Response, ifA.Stable,
                              ifA.APUF_Challenge, ifA.APUF_Pulse, ifA.APUF_Reset}, 64'h1);
        repeat (3) tick();
        rstN = 1'b1;
        repeat (120) tick();
        check("abort_no_done", 64'(doneCnt[0] - base), 64'd0);
        fillRandom(0);
        startRun(0, 32'hA5A55A5A);
        waitDone(0, 300, cyc);
        check("abort_rerun_cyc", 64'(cyc), 64'd96);
        check("abort_rerun_resp", 64'(getResp(0)), 64'(mResp[0]));
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
